// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: requester-side bus and ADC serial pins of the scan sequencer
interface adc_scan_sequencer_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req;
  logic [3*N_REQ-1:0] chan;
  logic [N_REQ-1:0] sgl;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic [9:0] result;
  logic busy;
  logic AD_CLK;
  logic CS;
  logic DIN;
  logic DOUT;
  modport master(input req, chan, sgl, DOUT, output grant, done, result, busy, AD_CLK, CS, DIN);
  modport slave(output req, chan, sgl, DOUT, input grant, done, result, busy, AD_CLK, CS, DIN);
endinterface

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin arbiter and SPI command/readback engine for a shared 8-channel 10-bit ADC
module adc_scan_sequencer #(
  parameter int CLK_DIV = 1350,
  parameter int N_REQ = 4,
  parameter int CS_IDLE = 2
) (
  input logic clk,
  input logic rst_n,
  adc_scan_sequencer_if.master bus
);
  localparam int HW = $clog2(CLK_DIV);
  localparam int IDLE_CLK = CS_IDLE * 2 * CLK_DIV;
  localparam int IW = (IDLE_CLK > 2) ? $clog2(IDLE_CLK) : 1;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_CSHI} state_t;
  state_t r_state;
  logic [2:0] r_ptr;
  logic [HW-1:0] r_hcnt;
  logic [IW-1:0] r_icnt;
  logic [4:0] r_k;
  logic [2:0] r_chan;
  logic r_sgl;
  logic [9:0] r_shift;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic [9:0] r_result;
  logic r_busy;
  logic r_ad_clk;
  logic r_cs;
  logic r_din;
  logic w_found;
  logic [2:0] w_sel;
  logic [3:0] w_idx;
  logic [2:0] w_nptr;
  logic w_din_next;
  assign bus.grant = r_grant;
  assign bus.done = r_done;
  assign bus.result = r_result;
  assign bus.busy = r_busy;
  assign bus.AD_CLK = r_ad_clk;
  assign bus.CS = r_cs;
  assign bus.DIN = r_din;
  assign w_nptr = (w_sel == 3'(N_REQ - 1)) ? 3'd0 : w_sel + 3'd1;
  assign w_din_next = (r_k == 5'd1) ? r_sgl :
                      (r_k == 5'd2) ? r_chan[2] :
                      (r_k == 5'd3) ? r_chan[1] :
                      (r_k == 5'd4) ? r_chan[0] : 1'b0;
  // first requesting index at or after ptr, scanning backwards so the nearest one wins
  always_comb begin
    w_found = 1'b0;
    w_sel = 3'd0;
    w_idx = 4'd0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      w_idx = {1'b0, r_ptr} + 4'(j);
      w_idx = (w_idx >= 4'(N_REQ)) ? w_idx - 4'(N_REQ) : w_idx;
      if (1'(bus.req >> w_idx)) begin
        w_found = 1'b1;
        w_sel = w_idx[2:0];
      end
    end
  end
  // sequencer FSM: arbitrate, clock out the command, shift in the result, hold CS high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr <= 3'd0;
      r_hcnt <= '0;
      r_icnt <= '0;
      r_k <= 5'd0;
      r_chan <= 3'd0;
      r_sgl <= 1'b0;
      r_shift <= 10'd0;
      r_grant <= '0;
      r_done <= '0;
      r_result <= 10'd0;
      r_busy <= 1'b0;
      r_ad_clk <= 1'b0;
      r_cs <= 1'b1;
      r_din <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_state <= S_CONV;
          r_grant <= N_REQ'(1) << w_sel;
          r_busy <= 1'b1;
          r_cs <= 1'b0;
          r_din <= 1'b1;
          r_chan <= 3'(bus.chan >> ({2'b0, w_sel} * 5'd3));
          r_sgl <= 1'(bus.sgl >> w_sel);
          r_ptr <= w_nptr;
          r_hcnt <= '0;
          r_k <= 5'd0;
          r_ad_clk <= 1'b0;
        end
        S_CONV: if (r_hcnt == HW'(CLK_DIV - 1)) begin
          r_hcnt <= '0;
          if (!r_ad_clk && r_k == 5'd17) begin
            r_cs <= 1'b1;
            r_din <= 1'b0;
            r_result <= r_shift;
            r_done <= r_grant;
            r_grant <= '0;
            r_icnt <= '0;
            r_state <= S_CSHI;
          end else if (!r_ad_clk) begin
            r_ad_clk <= 1'b1;
            r_k <= r_k + 5'd1;
            if (r_k >= 5'd7) r_shift <= {r_shift[8:0], bus.DOUT};
          end else begin
            r_ad_clk <= 1'b0;
            r_din <= w_din_next;
          end
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
        S_CSHI: if (r_icnt == IW'(IDLE_CLK - 1)) begin
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_icnt <= r_icnt + 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_done <= '0;
          r_result <= 10'd0;
          r_busy <= 1'b0;
          r_ad_clk <= 1'b0;
          r_cs <= 1'b1;
          r_din <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Shared-access controller for the board's 8-channel, 10-bit SPI ADC (start/SGL/D2..D0 command protocol, 10-bit MSB-first result). It arbitrates conversion requests from up to N_REQ requesters (throttle input, phase-current sense, bus voltage, …) round-robin, drives the ADC serial pins, and returns each result to the requester that asked for it. It replaces free-running, single-channel ADC bit-banging inside the commutation top level.

## Interface
- CLK_DIV, 1350: clk cycles per AD_CLK half-period (27 MHz → 10 kHz AD_CLK); legal range ≥ 2.
- N_REQ, 4: number of requesters; legal range 1..8.
- CS_IDLE, 2: full AD_CLK periods that CS is held high between conversions.

Ports (clk and rst_n: one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  level conversion request per requester
- chan  in  3*N_REQ  channel for requester i at [3i+2:3i]
- sgl  in  N_REQ  1 = single-ended, 0 = differential, per requester
- grant  out  N_REQ  one-hot; high for the requester being served
- done  out  N_REQ  one-clk pulse; result valid for that requester
- result  out  10  last conversion value; held until the next done
- busy  out  1  conversion or CS-idle interval in progress
- AD_CLK  out  1  ADC serial clock; low while CS is high
- CS  out  1  ADC chip select, active-low
- DIN  out  1  command bits to ADC
- DOUT  in  1  data from ADC

## Operation
- States: IDLE → CONV → CSHI → IDLE.
- IDLE: if any req bit is set, pick the first set bit at or after pointer `ptr` (wrapping). Then:
  - Latch that requester's chan and sgl.
  - Assert grant[i] and busy; drive CS=0 and DIN=1 (start bit); enter CONV.
  - Set ptr to i+1 mod N_REQ.
- CONV: half-period counter 0..CLK_DIV-1; AD_CLK toggles at each wrap. Rise index k counts 1..17.
  - DIN changes only on AD_CLK falling edges. After rise 1 it drives sgl; after rise 2, chan[2]; after 3, chan[1]; after 4, chan[0]; after 5 and later, 0.
  - Rises 6 and 7 are ignored (sample period and null bit).
  - DOUT is sampled into a shift register on rises 8..17: B9 first, B0 last.
- After rise 17, on the next falling wrap:
  - AD_CLK=0, CS=1, DIN=0.
  - result takes the shifted value.
  - done[i] pulses for 1 clk; grant goes low on the same edge.
  - Enter CSHI.
- CSHI: wait CS_IDLE*2*CLK_DIV clk with AD_CLK low, then drop busy and return to IDLE.
- chan/sgl/req changes during CONV/CSHI have no effect. Dropping req mid-conversion does not abort; done still pulses.
- req is a level. A requester still asserting req after done is served again on its next round-robin turn.
- Default state is unreachable; it returns to IDLE with outputs at reset values.
- Counter widths come from $clog2 of CLK_DIV and of CS_IDLE*2*CLK_DIV.

## Timing
- Reset values: grant=0, done=0, result=0, busy=0, AD_CLK=0, CS=1, DIN=0, ptr=0, state IDLE.
- Asserting rst_n low mid-conversion forces the reset values immediately. No done pulse is issued, and the next conversion starts from a full command.
- Request to grant: one clk edge when idle; req is sampled on the edge that enters CONV.
- Grant to done: 35*CLK_DIV clk (one leading low half-period plus 17 full AD_CLK periods).
- Conversion-to-conversion period under continuous request: (35 + 2*CS_IDLE)*CLK_DIV + 1 clk.
- The first AD_CLK rise occurs CLK_DIV clk after CS falls, so DIN setup is one half-period.
- Simultaneous requests are resolved solely by ptr. No requester waits more than N_REQ-1 conversions.

## Test plan
- Single request: CLK_DIV=4; req[0]=1, chan=3, sgl=1; ADC model returns 0x2A5. Required: DIN bits at rises 1..5 = 1,1,0,1,1; done[0] 140 clk after grant; result=0x2A5.
- Round robin: all req held high. Required: grant order 0,1,2,3,0,1, with each done paired to the matching grant.
- Pointer: serve requester 1, then raise req[0] and req[3] together. Required: 3 served before 0.
- Differential plus early drop: chan=5, sgl=0, req dropped after 10 clk. Required: DIN bits 1,0,1,0,1; conversion completes; done pulses once and is not repeated.
- Reset mid-conversion: assert rst_n=0 at rise 9. Required: CS=1, AD_CLK=0, grant=0, result=0 immediately; with req held, the next conversion begins cleanly and DIN shows the start bit.
